// File: rtl/seqgen_pkg.sv
// Shared types and constants for the serial pattern generator and its LFSR filler.
package seqgen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_SEED       = 16'hACE1;
    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS       = 16'h002D;
    localparam logic [3:0]  DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Serial valid/ready stream between the pattern generator and its consumer.
interface seq_pattern_gen_if;

    logic dout;
    logic dout_valid;
    logic dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);

endinterface

// File: rtl/seqgen_lfsr.sv
// 16-bit Fibonacci LFSR producing pseudo-random gap filler; advances only when adv_i is high.
module seqgen_lfsr
    import seqgen_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic adv_i,
    output logic bit_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv_i) begin
            lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[0];

endmodule

// File: rtl/seq_pattern_gen.sv
// Bit-serial pattern transmitter: PATTERN sent MSB-first, rpt times, gap filler bits between.
// Optional: SEQGEN_LFSR_FILL_EN replaces the constant-0 gap filler with LFSR bits.
module seq_pattern_gen
    import seqgen_pkg::*;
#(
    parameter int unsigned       PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = DEFAULT_PATTERN,
    parameter int unsigned       CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   rpt,
    input  logic [CNT_W-1:0]   gap,
    seq_pattern_gen_if.master  tx,
    output logic               busy,
    output logic               done
);

    localparam int unsigned      IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] gap_len_q, gap_len_d;

    logic dout_c;
    logic valid_c;
    logic hs;
    logic fill_bit;

    assign hs = valid_c & tx.dout_ready;

`ifdef SEQGEN_LFSR_FILL_EN
    logic lfsr_adv;

    assign lfsr_adv = (state_q == GAP) & hs;

    seqgen_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .adv_i (lfsr_adv),
        .bit_o (fill_bit)
    );
`else
    assign fill_bit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
        gap_len_d = gap_len_q;
        dout_c    = 1'b0;
        valid_c   = 1'b0;
        busy      = (state_q != IDLE);
        done      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (rpt != '0) begin
                        rep_cnt_d = rpt;
                        gap_len_d = gap;
                        bit_idx_d = IDX_LAST;
                        state_d   = SEND;
                    end else begin
                        state_d   = FIN;
                    end
                end
            end
            SEND: begin
                valid_c = 1'b1;
                dout_c  = PATTERN[bit_idx_q];
                if (valid_c & tx.dout_ready) begin
                    if (bit_idx_q == '0) begin
                        bit_idx_d = IDX_LAST;
                        rep_cnt_d = rep_cnt_q - CNT_ONE;
                        if (rep_cnt_q == CNT_ONE) begin
                            state_d = FIN;
                        end else if (gap_len_q != '0) begin
                            gap_cnt_d = gap_len_q;
                            state_d   = GAP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q - IDX_ONE;
                    end
                end
            end
            GAP: begin
                valid_c = 1'b1;
                dout_c  = fill_bit;
                if (valid_c & tx.dout_ready) begin
                    gap_cnt_d = gap_cnt_q - CNT_ONE;
                    if (gap_cnt_q == CNT_ONE) begin
                        state_d = SEND;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            gap_len_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            gap_len_q <= gap_len_d;
        end
    end

    assign tx.dout       = dout_c;
    assign tx.dout_valid = valid_c;

endmodule
